// File: rtl/pattern_count_pkg.sv
// pattern_count_pkg: shared FSM state type and default parameters for the pattern counter.
package pattern_count_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_PAT_W = 3;
  localparam logic [15:0] DEF_PATTERN = 16'b101;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_IDX_W = 8;
endpackage

// File: rtl/pattern_count_stream_match.sv
// pattern_match_shift: history shift register and fill counter; flags a match including the current beat.
module pattern_match_shift
  import pattern_count_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_bit,
  input  logic i_ovl,
  output logic o_match
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  logic [PAT_W-1:0] r_hist, w_hist;
  logic [FW-1:0] r_fill, w_fill;
  always_comb begin
    w_hist = {r_hist[PAT_W-2:0], i_bit};
    w_fill = (r_fill == FULL) ? FULL : r_fill + 1'b1;
    o_match = i_en && (w_fill == FULL) && (w_hist == PATTERN);
  end
  // Non-overlap mode restarts the fill so the next match needs PAT_W fresh bits.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_en) begin
      r_hist <= w_hist;
      r_fill <= (o_match && !i_ovl) ? '0 : w_fill;
    end
  end
endmodule

// File: rtl/pattern_count_stream.sv
// pattern_count_stream: counts PATTERN occurrences per serial frame and hands the count out with valid/ready.
// Optional PATCNT_FIRST_POS_EN adds first_pos/first_vld (index of the bit completing the first match).
module pattern_count_stream
  import pattern_count_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int CNT_W = DEF_CNT_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  input  logic             mode_ovl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
`ifdef PATCNT_FIRST_POS_EN
  ,
  output logic [IDX_W-1:0] first_pos,
  output logic             first_vld
`endif
);
  state_t r_state;
  logic r_ovl, r_sat;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic w_acc, w_last, w_ovl, w_match, w_clr;
  assign in_ready = r_state != DONE;
  assign out_valid = r_state == DONE;
  assign w_acc = in_valid && in_ready;
  assign w_last = in_last || (&r_idx);
  assign w_ovl = (r_state == IDLE) ? mode_ovl : r_ovl;
  assign w_clr = out_valid && out_ready;
  assign out_count = r_cnt;
  assign out_sat = r_sat;
  pattern_match_shift #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_match (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_acc), .i_bit(in_bit), .i_ovl(w_ovl), .o_match(w_match)
  );
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_state <= IDLE;
      r_ovl <= 1'b0;
      r_cnt <= '0;
      r_sat <= 1'b0;
      r_idx <= '0;
    end else if (w_acc) begin
      r_state <= w_last ? DONE : RUN;
      r_ovl <= w_ovl;
      r_idx <= r_idx + 1'b1;
      if (w_match) begin
        if (&r_cnt) r_sat <= 1'b1;
        else r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`ifdef PATCNT_FIRST_POS_EN
  logic [IDX_W-1:0] r_first_pos;
  logic r_first_vld;
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_first_pos <= '0;
      r_first_vld <= 1'b0;
    end else if (w_match && !r_first_vld) begin
      r_first_pos <= r_idx;
      r_first_vld <= 1'b1;
    end
  end
  assign first_pos = r_first_pos;
  assign first_vld = r_first_vld;
`endif
endmodule
